oled_ram_write: RTL and testbench
=================================

# oled_ram_write

Writer side of the 1024-byte OLED frame RAM. Accepts single-pixel set/clear/toggle commands and whole-screen fill commands, and performs byte-wide read-modify-write or burst writes on the RAM's port A. The refresh path independently scans the same RAM through port B and streams it to the display. The address map here matches the scan order of that refresh path.

## Interface
- RD_LAT, 2, port-A read latency in cycles: q valid RD_LAT cycles after the clock edge that samples rden/addr; legal 1..7

- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present; source holds all cmd fields stable until accepted
- cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready at a rising edge
- cmd_op  in  2  00 set pixel, 01 clear pixel, 10 toggle pixel, 11 fill screen
- cmd_x  in  7  column 0..127
- cmd_y  in  6  row 0..63, where 0 is the top row
- cmd_fill  in  8  byte written to all 1024 addresses for op 11
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse when a command completes
- ram_addr  out  10  port-A address
- ram_rden  out  1  port-A read enable
- ram_wren  out  1  port-A write enable
- ram_wrdata  out  8  port-A write data
- ram_q  in  8  port-A read data

## Operation
- Address map: page = cmd_y[5:3], addr = {~page, cmd_x}, so page 7 maps to addresses 0..127 and page 0 to 896..1023. Bit index = cmd_y[2:0] (bit 0 is the top row of the page).
- On accept, latch op, x, y and fill into internal registers. Later changes on the cmd inputs have no effect.
- States: IDLE, RD, WAIT, MOD, WR, FILL, DONE.
- IDLE → RD on accept of op 00/01/10. IDLE → FILL on accept of op 11.
- RD (1 cycle): ram_rden=1, ram_addr=mapped address. Then go to WAIT.
- WAIT (RD_LAT-1 cycles, counted by a 3-bit counter; skipped when RD_LAT=1): ram_rden=0. Then go to MOD.
- MOD (1 cycle): sample ram_q and register the result in ram_wrdata:
  - op 00: ram_q | (1<<bit)
  - op 01: ram_q & ~(1<<bit)
  - op 10: ram_q ^ (1<<bit)
  - Then go to WR.
- WR (1 cycle): ram_wren=1, ram_addr unchanged. Then go to DONE.
- FILL: 11-bit counter from 0. Each cycle drives ram_wren=1, ram_addr=cnt[9:0], ram_wrdata=latched fill byte. When cnt reaches 1023, go to DONE. cnt=1024 is the terminal value and is never written.
- DONE (1 cycle): done=1, busy=0, ram_wren=0, then IDLE.
- Other bits of the RMW byte are preserved exactly.
- The block does not arbitrate against port B. The RAM is true dual-port, and a refresh-scan read of the same address in the WR cycle may return either the old or the new byte; both are acceptable.

## Timing
- Reset values (async, immediate): state IDLE, cmd_ready=1, busy=0, done=0, ram_rden=0, ram_wren=0, ram_addr=0, ram_wrdata=0, counters 0.
- All outputs except cmd_ready are registered. cmd_ready = (state==IDLE).
- Pixel command, accept at edge A (cycle numbers are cycles after that edge):
  - RD: cycle 1
  - WAIT: cycles 2..RD_LAT
  - MOD: cycle RD_LAT+1
  - WR: cycle RD_LAT+2
  - done: cycle RD_LAT+3
  - cmd_ready is high again in cycle RD_LAT+4.
  - With RD_LAT=2: wren in cycle 4, done in cycle 5; minimum pixel period is 6 cycles.
- Fill, accept at A: wren high in cycles 1..1024 (addresses 0..1023, one per cycle, no gaps), done in cycle 1025.
- cmd_valid while busy is ignored and not queued; the source must hold it.
- done is never asserted in the same cycle as cmd_ready.
- Reset mid-operation aborts immediately: no further wren, and partially written RAM is left as is. After release, the block is in IDLE.

## Test plan
- Reset: assert rst_n=0 mid-FILL at cnt≈500 → ram_wren falls to 0 asynchronously; after release cmd_ready=1, busy=0, and no done pulse occurs.
- Set pixel: RAM all 0x00, op 00, x=5, y=0 → one read of addr 901 (page 0), write 0x01 to addr 901 in cycle 4, done in cycle 5 (RD_LAT=2).
- Clear/toggle: addr 0 preset to 0xFF, op 01 with x=0, y=59 (page 7, bit 3) → write 0xF7 to addr 0. Then op 10 with the same coordinates → write 0xFF.
- Fill: op 11, cmd_fill=0xA5 → exactly 1024 consecutive wren cycles, addresses 0..1023, all data 0xA5; done in cycle 1025; ram_rden never asserted.
- Back-to-back: hold cmd_valid high with two pixel commands → second accept occurs in the first cycle cmd_ready=1 after done; first command's fields are unaffected by changes to the cmd inputs after accept.
- Latency sweep: RD_LAT=1 and RD_LAT=3 with a RAM model of matching latency → correct RMW data, with wren in cycle RD_LAT+2.

Source files
------------

// File: rtl/oled_ram_write.sv
// oled_ram_write: single-pixel set/clear/toggle and whole-screen fill writer on OLED frame RAM port A.
// Latency: pixel read-modify-write completes (done) RD_LAT+3 cycles after accept; fill completes 1025 cycles after accept.
// Backpressure: cmd_ready is high only in IDLE; a command offered while busy is not queued and must be held by the source.
module oled_ram_write #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [6:0] cmd_x,
  input  logic [5:0] cmd_y,
  input  logic [7:0] cmd_fill,
  output logic       busy,
  output logic       done,
  output logic [9:0] ram_addr,
  output logic       ram_rden,
  output logic       ram_wren,
  output logic [7:0] ram_wrdata,
  input  logic [7:0] ram_q
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WAIT, S_MOD, S_WR, S_FILL, S_DONE
  } state_e;

  localparam logic [1:0] OP_SET  = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_FILL = 2'b11;
  // WAIT spans RD_LAT-1 cycles: counter runs 0..RD_LAT-2.
  localparam logic [2:0] WAIT_LAST = 3'((RD_LAT >= 2) ? (RD_LAT - 2) : 0);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [10:0] fcnt_q, fcnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rden_q, rden_d;
  logic        wren_q, wren_d;
  logic [9:0]  addr_q, addr_d;
  logic [7:0]  wrdata_q, wrdata_d;
  logic [7:0]  bit_mask;

  // The pixel byte address is captured straight into ram_addr at accept, so
  // only the op and the bit index need their own latches; the fill byte is
  // parked in ram_wrdata for the whole burst.
  assign bit_mask   = 8'h01 << bit_q;
  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = busy_q;
  assign done       = done_q;
  assign ram_addr   = addr_q;
  assign ram_rden   = rden_q;
  assign ram_wren   = wren_q;
  assign ram_wrdata = wrdata_q;

  // Next-state and next-output logic; all outputs are registered, so each
  // value here is what the port shows in the following cycle.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    bit_d    = bit_q;
    wcnt_d   = wcnt_q;
    fcnt_d   = fcnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rden_d   = 1'b0;
    wren_d   = 1'b0;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          bit_d  = cmd_y[2:0];
          busy_d = 1'b1;
          if (cmd_op == OP_FILL) begin
            state_d  = S_FILL;
            fcnt_d   = '0;
            addr_d   = '0;
            wrdata_d = cmd_fill;
            wren_d   = 1'b1;
          end else begin
            // Page 7 sits at the bottom of the address space to match the
            // refresh scan order.
            state_d = S_RD;
            addr_d  = {~cmd_y[5:3], cmd_x};
            rden_d  = 1'b1;
          end
        end
      end
      S_RD: begin
        wcnt_d  = '0;
        state_d = (RD_LAT > 1) ? S_WAIT : S_MOD;
      end
      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          state_d = S_MOD;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      S_MOD: begin
        case (op_q)
          OP_SET:  wrdata_d = ram_q | bit_mask;
          OP_CLR:  wrdata_d = ram_q & ~bit_mask;
          default: wrdata_d = ram_q ^ bit_mask;
        endcase
        wren_d  = 1'b1;
        state_d = S_WR;
      end
      S_WR: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      S_FILL: begin
        fcnt_d = fcnt_q + 11'd1;
        if (fcnt_q == 11'd1023) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          wren_d = 1'b1;
          addr_d = fcnt_d[9:0];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any command in flight at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      bit_q    <= '0;
      wcnt_q   <= '0;
      fcnt_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rden_q   <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      wrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      bit_q    <= bit_d;
      wcnt_q   <= wcnt_d;
      fcnt_q   <= fcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rden_q   <= rden_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
    end
  end

endmodule

// File: tb/tb_oled_ram_write.sv
// tb_oled_ram_write: directed checks of oled_ram_write at RD_LAT 1, 2 and 3.
// Latency: each instance has a RAM model whose read latency matches its RD_LAT.
// Backpressure: commands are offered only when the targeted instances are idle, except the held back-to-back case.
module tb_oled_ram_write;

  logic       clk;
  logic       rst_n;
  logic [2:0] vld, rdy, busy, done, rden, wren;
  logic [1:0] op;
  logic [6:0] x;
  logic [5:0] y;
  logic [7:0] fill;
  logic [9:0] addr [3];
  logic [7:0] wdat [3];
  logic [7:0] q    [3];

  // RAM models and write/read monitors, one slot per instance.
  logic [7:0] mem  [3][1024];
  logic [7:0] pipe [3][3];
  int cyc = 0;
  int wr_cnt [3] = '{default:0};
  int rd_cnt [3] = '{default:0};
  int done_cnt [3] = '{default:0};
  int seq_err [3] = '{default:0};
  int ovl_err [3] = '{default:0};
  int acc_cyc [3] = '{default:0};
  int first_wr_cyc [3] = '{default:0};
  int last_wr_cyc [3] = '{default:0};
  int done_cyc [3] = '{default:0};
  logic [9:0] first_addr [3], last_addr [3], rd_addr [3];
  logic [7:0] first_dat [3], last_dat [3];
  logic [2:0] prev_wren = 3'b000;
  int acc_log [$];
  int done_log [$];
  int wa_log [$];
  int wd_log [$];

  int n_chk = 0;
  int n_pass = 0;

  oled_ram_write #(.RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(vld[0]), .cmd_ready(rdy[0]),
    .cmd_op(op), .cmd_x(x), .cmd_y(y), .cmd_fill(fill),
    .busy(busy[0]), .done(done[0]), .ram_addr(addr[0]), .ram_rden(rden[0]),
    .ram_wren(wren[0]), .ram_wrdata(wdat[0]), .ram_q(q[0])
  );
  oled_ram_write #(.RD_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(vld[1]), .cmd_ready(rdy[1]),
    .cmd_op(op), .cmd_x(x), .cmd_y(y), .cmd_fill(fill),
    .busy(busy[1]), .done(done[1]), .ram_addr(addr[1]), .ram_rden(rden[1]),
    .ram_wren(wren[1]), .ram_wrdata(wdat[1]), .ram_q(q[1])
  );
  oled_ram_write #(.RD_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(vld[2]), .cmd_ready(rdy[2]),
    .cmd_op(op), .cmd_x(x), .cmd_y(y), .cmd_fill(fill),
    .busy(busy[2]), .done(done[2]), .ram_addr(addr[2]), .ram_rden(rden[2]),
    .ram_wren(wren[2]), .ram_wrdata(wdat[2]), .ram_q(q[2])
  );

  // Read data appears RD_LAT cycles after the sampling edge; other slots hold junk.
  assign q[0] = pipe[0][0];
  assign q[1] = pipe[1][1];
  assign q[2] = pipe[2][2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM behaviour plus bookkeeping of every accept, read, write and done.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (wren[i]) mem[i][addr[i]] <= wdat[i];
      pipe[i][0] <= rden[i] ? mem[i][addr[i]] : 8'hEE;
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
      if (vld[i] && rdy[i]) acc_cyc[i] <= cyc;
      if (rden[i]) begin
        rd_cnt[i]  <= rd_cnt[i] + 1;
        rd_addr[i] <= addr[i];
      end
      if (wren[i]) begin
        wr_cnt[i]      <= wr_cnt[i] + 1;
        last_addr[i]   <= addr[i];
        last_dat[i]    <= wdat[i];
        last_wr_cyc[i] <= cyc;
        if (!prev_wren[i]) begin
          first_addr[i]   <= addr[i];
          first_dat[i]    <= wdat[i];
          first_wr_cyc[i] <= cyc;
        end else if (addr[i] != last_addr[i] + 10'd1 || wdat[i] != last_dat[i]) begin
          seq_err[i] <= seq_err[i] + 1;
        end
      end
      prev_wren[i] <= wren[i];
      if (done[i]) begin
        done_cnt[i] <= done_cnt[i] + 1;
        done_cyc[i] <= cyc;
        if (rdy[i]) ovl_err[i] <= ovl_err[i] + 1;
      end
    end
    if (vld[1] && rdy[1]) acc_log.push_back(cyc);
    if (done[1]) done_log.push_back(cyc);
    if (wren[1]) begin
      wa_log.push_back(32'(addr[1]));
      wd_log.push_back(32'(wdat[1]));
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Offer one command for a single cycle to the masked (idle) instances.
  task automatic issue(input logic [2:0] mask, input logic [1:0] o, input logic [6:0] xx,
                       input logic [5:0] yy, input logic [7:0] f);
    @(negedge clk);
    op = o; x = xx; y = yy; fill = f; vld = mask;
    @(negedge clk);
    vld = 3'b000;
  endtask

  task automatic run_fill(input string name, input logic [7:0] f);
    int wc, rc, sc;
    int dc [3];
    wc = wr_cnt[1]; rc = rd_cnt[1]; sc = seq_err[1];
    for (int i = 0; i < 3; i++) dc[i] = done_cnt[i];
    issue(3'b111, 2'b11, 7'd0, 6'd0, f);
    check({name, "_busy"}, 32'(busy), 'h7);
    repeat (1030) @(negedge clk);
    check({name, "_wr_count"}, wr_cnt[1] - wc, 1024);
    check({name, "_first_addr"}, 32'(first_addr[1]), 0);
    check({name, "_first_data"}, 32'(first_dat[1]), 32'(f));
    check({name, "_last_addr"}, 32'(last_addr[1]), 1023);
    check({name, "_seq_err"}, seq_err[1] - sc, 0);
    check({name, "_first_wr_cyc"}, first_wr_cyc[1] - acc_cyc[1], 1);
    check({name, "_last_wr_cyc"}, last_wr_cyc[1] - acc_cyc[1], 1024);
    check({name, "_done_cyc"}, done_cyc[1] - acc_cyc[1], 1025);
    check({name, "_no_rden"}, rd_cnt[1] - rc, 0);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s_done_lat%0d", name, i + 1), done_cnt[i] - dc[i], 1);
  endtask

  task automatic run_pixel(input string name, input logic [1:0] o, input logic [6:0] xx,
                           input logic [5:0] yy, input int exp_addr, input int exp_dat);
    int wc [3];
    int rc [3];
    int dc [3];
    for (int i = 0; i < 3; i++) begin
      wc[i] = wr_cnt[i]; rc[i] = rd_cnt[i]; dc[i] = done_cnt[i];
    end
    issue(3'b111, o, xx, yy, 8'h00);
    check({name, "_busy"}, 32'(busy), 'h7);
    check({name, "_not_ready"}, 32'(rdy), 0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_rd_count_lat%0d", name, i + 1), rd_cnt[i] - rc[i], 1);
      check($sformatf("%s_rd_addr_lat%0d", name, i + 1), 32'(rd_addr[i]), exp_addr);
      check($sformatf("%s_wr_count_lat%0d", name, i + 1), wr_cnt[i] - wc[i], 1);
      check($sformatf("%s_wr_addr_lat%0d", name, i + 1), 32'(last_addr[i]), exp_addr);
      check($sformatf("%s_wr_data_lat%0d", name, i + 1), 32'(last_dat[i]), exp_dat);
      check($sformatf("%s_wr_cyc_lat%0d", name, i + 1), last_wr_cyc[i] - acc_cyc[i], i + 3);
      check($sformatf("%s_done_cyc_lat%0d", name, i + 1), done_cyc[i] - acc_cyc[i], i + 4);
      check($sformatf("%s_done_count_lat%0d", name, i + 1), done_cnt[i] - dc[i], 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dc0, a0, d0, w0;
    rst_n = 1'b1; vld = 3'b000; op = 2'b00; x = '0; y = '0; fill = '0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_wren", 32'(wren), 0);
    check("rst_rden", 32'(rden), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ready", 32'(rdy), 'h7);
    check("rst_addr", 32'(addr[1]), 0);
    check("rst_wrdata", 32'(wdat[1]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_fill("fill_a5", 8'hA5);

    // Reset in the middle of a fill burst.
    issue(3'b111, 2'b11, 7'd0, 6'd0, 8'h3C);
    repeat (500) @(negedge clk);
    check("midfill_wren_before", 32'(wren), 'h7);
    dc0 = done_cnt[1];
    #2 rst_n = 1'b0;
    #1;
    check("midfill_wren_async", 32'(wren), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midfill_ready", 32'(rdy), 'h7);
    check("midfill_busy", 32'(busy), 0);
    check("midfill_wren_after", 32'(wren), 0);
    check("midfill_no_done", done_cnt[1] - dc0, 0);

    run_fill("fill_00", 8'h00);
    run_pixel("set_x5_y0", 2'b00, 7'd5, 6'd0, 901, 'h01);
    run_fill("fill_ff", 8'hFF);
    run_pixel("clr_x0_y59", 2'b01, 7'd0, 6'd59, 0, 'hF7);
    run_pixel("tgl_x0_y59", 2'b10, 7'd0, 6'd59, 0, 'hFF);
    run_pixel("tgl_x127_y7", 2'b10, 7'd127, 6'd7, 1023, 'h7F);

    // Back-to-back on the RD_LAT=2 instance with cmd_valid held high.
    a0 = acc_log.size(); d0 = done_log.size(); w0 = wa_log.size();
    @(negedge clk);
    op = 2'b01; x = 7'd10; y = 6'd12; vld = 3'b010;
    @(negedge clk);
    op = 2'b10; x = 7'd20; y = 6'd63;
    for (int k = 0; k < 20 && acc_log.size() < a0 + 2; k++) @(negedge clk);
    vld = 3'b000;
    check("b2b_accepts", acc_log.size() - a0, 2);
    repeat (10) @(negedge clk);
    check("b2b_writes", wa_log.size() - w0, 2);
    check("b2b_first_addr", wa_log[w0], 778);
    check("b2b_first_data", wd_log[w0], 'hEF);
    check("b2b_second_addr", wa_log[w0 + 1], 20);
    check("b2b_second_data", wd_log[w0 + 1], 'h7F);
    check("b2b_first_done", done_log[d0] - acc_log[a0], 5);
    check("b2b_accept_after_done", acc_log[a0 + 1] - done_log[d0], 1);
    check("b2b_period", acc_log[a0 + 1] - acc_log[a0], 6);

    check("done_with_ready", ovl_err[0] + ovl_err[1] + ovl_err[2], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
